// File: rtl/timer_preset_ctrl.sv
// ---------------------------------------------------------------------------
// timer_preset_ctrl
//
// Control stage in front of the 4-digit BCD countdown counter. Debounces the
// start, mode and increment pushbuttons. Lets the user edit the preset digits
// while idle. Pulses the counter's active-low load (ld_n_o) when a run
// starts. Generates the one-clock count-enable tick (sel_in_o) while running.
// Follows the counter's terminal flag into a DONE state.
//
// Optional build macro:
//   AUTOREPEAT_EN  holding the increment button in IDLE auto-repeats
//                  (first repeat after HOLD_CYC, then every REP_CYC clocks)
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous reset, active-low
//   btn_start_i  in   raw start/pause button, active-high
//   btn_mode_i   in   raw digit-select / abort button, active-high
//   btn_inc_i    in   raw digit-increment button, active-high
//   zero_i       in   counter terminal flag (count == 0000)
//   in0_o..in3_o out  preset BCD digits (in3 = s ones, in2 = s tens, in1 = min ones)
//   ld_n_o       out  registered active-low load pulse to the counter
//   sel_in_o     out  one-clock count-enable tick
//   edit_sel_o   out  index of the digit being edited
//   running_o    out  high in RUN
//   done_o       out  high in DONE
//
// state | meaning
// IDLE  | digits editable, waiting for start
// RUN   | counter enabled, prescaler advancing
// PAUSE | count frozen, prescaler phase held
// DONE  | counter reached 0000
// ---------------------------------------------------------------------------
module timer_preset_ctrl #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned DEB_DIV  = 250_000,
    parameter logic [3:0]  PRESET0  = 4'd0,
    parameter logic [3:0]  PRESET1  = 4'd0,
    parameter logic [3:0]  PRESET2  = 4'd1,
    parameter logic [3:0]  PRESET3  = 4'd5,
    parameter int unsigned HOLD_CYC = 25_000_000,
    parameter int unsigned REP_CYC  = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start_i,
    input  logic       btn_mode_i,
    input  logic       btn_inc_i,
    input  logic       zero_i,
    output logic [3:0] in0_o,
    output logic [3:0] in1_o,
    output logic [3:0] in2_o,
    output logic [3:0] in3_o,
    output logic       ld_n_o,
    output logic       sel_in_o,
    output logic [1:0] edit_sel_o,
    output logic       running_o,
    output logic       done_o
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_DIV - 1);

    localparam int B_START = 0;
    localparam int B_MODE  = 1;
    localparam int B_INC   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_q;
    logic [3:0][3:0] dig_q;
    logic [1:0]      edit_sel_q;
    logic            ld_n_q;
    logic            running_q;
    logic            done_q;

    // ------------------------------------------------------------------
    // Button conditioning: 2-flop synchroniser, then a 3-sample history
    // taken every DEB_DIV clocks. Level only flips on three equal samples.
    // ------------------------------------------------------------------
    logic [2:0]      sync1_q;
    logic [2:0]      sync2_q;
    logic [DW-1:0]   deb_cnt_q;
    logic            deb_tick;
    logic [2:0][2:0] hist_q;
    logic [2:0]      level_q;
    logic [2:0]      level_d;
    logic [2:0]      level_dly_q;
    logic [2:0]      pulse;
    logic            p_start;
    logic            p_mode;
    logic            p_inc;

    assign deb_tick = (deb_cnt_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_cnt_q   <= '0;
            hist_q      <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
        end else begin
            sync1_q     <= {btn_inc_i, btn_mode_i, btn_start_i};
            sync2_q     <= sync1_q;
            deb_cnt_q   <= deb_tick ? DEB_LAST : deb_cnt_q - 1'b1;
            if (deb_tick) begin
                for (int b = 0; b < 3; b++) begin
                    hist_q[b] <= {hist_q[b][1:0], sync2_q[b]};
                end
            end
            level_q     <= level_d;
            level_dly_q <= level_q;
        end
    end

    always_comb begin
        level_d = level_q;
        for (int b = 0; b < 3; b++) begin
            if (hist_q[b] == 3'b111) begin
                level_d[b] = 1'b1;
            end else if (hist_q[b] == 3'b000) begin
                level_d[b] = 1'b0;
            end
        end
    end

    // Pulse lands on the first cycle the debounced level is high.
    assign pulse   = level_q & ~level_dly_q;
    assign p_start = pulse[B_START];
    assign p_mode  = pulse[B_MODE];
    assign p_inc   = pulse[B_INC];

    // ------------------------------------------------------------------
    // Increment auto-repeat
    // ------------------------------------------------------------------
    logic rep_fire;

`ifdef AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
    localparam int RW = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
    localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYC - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REP_CYC - 1);

    logic [RW-1:0] rep_q;
    logic          rep_armed_q;

    // Armed only by a real press in IDLE, so entering IDLE with the button
    // already held does not produce a spurious increment.
    assign rep_fire = rep_armed_q && level_q[B_INC] && (rep_q == '0)
                      && (state_q == ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_q       <= '0;
            rep_armed_q <= 1'b0;
        end else if ((state_q != ST_IDLE) || !level_q[B_INC]) begin
            rep_q       <= '0;
            rep_armed_q <= 1'b0;
        end else if (p_inc) begin
            rep_q       <= HOLD_LAST;
            rep_armed_q <= 1'b1;
        end else if (rep_armed_q) begin
            rep_q       <= (rep_q == '0) ? REP_LAST : rep_q - 1'b1;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Prescaler: runs only in RUN, frozen in PAUSE/DONE, zeroed in IDLE so
    // every run starts with a full tick period.
    // ------------------------------------------------------------------
    logic [TW-1:0] presc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
        end else if (state_q == ST_IDLE) begin
            presc_q <= '0;
        end else if (state_q == ST_RUN) begin
            presc_q <= (presc_q == TICK_LAST) ? '0 : presc_q + 1'b1;
        end
    end

    assign sel_in_o = running_q && (presc_q == TICK_LAST);

    // ------------------------------------------------------------------
    // Sequencing FSM and preset digits
    // ------------------------------------------------------------------
    function automatic logic [3:0] bcd_inc(input logic [3:0] v, input logic [3:0] top);
        return (v >= top) ? 4'd0 : v + 4'd1;
    endfunction

    logic       digits_nz;
    logic [3:0] dig_top;

    assign digits_nz = |dig_q;
    assign dig_top   = (edit_sel_q == 2'd2) ? 4'd5 : 4'd9;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            dig_q      <= {PRESET3, PRESET2, PRESET1, PRESET0};
            edit_sel_q <= 2'd3;
            ld_n_q     <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ld_n_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (p_start && digits_nz) begin
                        // Load is held low during the first RUN cycle.
                        state_q   <= ST_RUN;
                        ld_n_q    <= 1'b0;
                        running_q <= 1'b1;
                    end else begin
                        if (p_inc || rep_fire) begin
                            dig_q[edit_sel_q] <= bcd_inc(dig_q[edit_sel_q], dig_top);
                        end
                        if (p_mode) begin
                            edit_sel_q <= edit_sel_q - 2'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (zero_i) begin
                        state_q   <= ST_DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (p_start) begin
                        state_q   <= ST_PAUSE;
                        running_q <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (p_start) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end else if (p_mode) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (p_start || p_mode) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign in0_o      = dig_q[0];
    assign in1_o      = dig_q[1];
    assign in2_o      = dig_q[2];
    assign in3_o      = dig_q[3];
    assign ld_n_o     = ld_n_q;
    assign edit_sel_o = edit_sel_q;
    assign running_o  = running_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_timer_preset_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timer_preset_ctrl
//
// Drives clean, bounced and overlapping button presses plus counter-zero
// events, and compares the preset controller against a press-level model
// of the timer's user interface. A per-cycle monitor checks the load pulse
// and the spacing of count ticks in RUN cycles.
// ---------------------------------------------------------------------------
module tb_timer_preset_ctrl;

    localparam int TICK = 10;
    localparam int DEB  = 2;
    localparam int HOLD = 40;
    localparam int REP  = 10;

    logic       clk;
    logic       rst;
    logic       btn_start, btn_mode, btn_inc, zero;
    logic [3:0] in0, in1, in2, in3;
    logic       ld_n, sel_in, running, done;
    logic [1:0] edit_sel;

    timer_preset_ctrl #(
        .TICK_DIV(TICK), .DEB_DIV(DEB), .HOLD_CYC(HOLD), .REP_CYC(REP)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_start_i(btn_start), .btn_mode_i(btn_mode), .btn_inc_i(btn_inc),
        .zero_i(zero),
        .in0_o(in0), .in1_o(in1), .in2_o(in2), .in3_o(in3),
        .ld_n_o(ld_n), .sel_in_o(sel_in), .edit_sel_o(edit_sel),
        .running_o(running), .done_o(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (press granularity) ----------------
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mst_t;
    mst_t m_st;
    int   m_dig[4];
    int   m_sel;
    int   m_loads = 0;

    function automatic void model_reset();
        m_st     = M_IDLE;
        m_dig[0] = 0; m_dig[1] = 0; m_dig[2] = 1; m_dig[3] = 5;
        m_sel    = 3;
    endfunction

    function automatic void model_press(input bit s, input bit m, input bit i);
        case (m_st)
            M_IDLE: begin
                if (s && (m_dig[0] + m_dig[1] + m_dig[2] + m_dig[3] != 0)) begin
                    m_st = M_RUN;
                    m_loads++;
                end else begin
                    if (i) m_dig[m_sel] = (m_dig[m_sel] + 1) % ((m_sel == 2) ? 6 : 10);
                    if (m) m_sel = (m_sel + 3) % 4;
                end
            end
            M_RUN:   if (s) m_st = M_PAUSE;
            M_PAUSE: begin
                if (s)      m_st = M_RUN;
                else if (m) m_st = M_IDLE;
            end
            M_DONE:  if (s || m) m_st = M_IDLE;
            default: m_st = M_IDLE;
        endcase
    endfunction

    // ---------------- per-cycle monitor ----------------
    bit   mon_en = 0;
    int   run_cnt = 0;
    int   ld_cnt = 0;
    logic prev_ld = 1'b1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (ld_n === 1'b0) begin
                chk("ld_1clk", prev_ld, 1);
                chk("ld_in_run", running, 1);
                run_cnt = 0;
                ld_cnt++;
            end
            chk("sel_in", sel_in, (running === 1'b1) && (run_cnt % TICK == TICK - 1));
            if (running === 1'b1) run_cnt++;
            prev_ld = ld_n;
        end
    end

    task automatic check_all();
        chk("in0", in0, m_dig[0]);
        chk("in1", in1, m_dig[1]);
        chk("in2", in2, m_dig[2]);
        chk("in3", in3, m_dig[3]);
        chk("edit_sel", edit_sel, m_sel);
        chk("running", running, m_st == M_RUN);
        chk("done", done, m_st == M_DONE);
        chk("ld_n_idle", ld_n, 1);
        chk("load_count", ld_cnt, m_loads);
    endtask

    task automatic drive_btn(input bit s, input bit m, input bit i, input int hold);
        @(negedge clk);
        btn_start = s; btn_mode = m; btn_inc = i;
        repeat (hold) @(negedge clk);
        btn_start = 0; btn_mode = 0; btn_inc = 0;
        repeat ($urandom_range(12, 18)) @(negedge clk);
    endtask

    task automatic press(input bit s, input bit m, input bit i);
        drive_btn(s, m, i, $urandom_range(12, 18));
        model_press(s, m, i);
        check_all();
    endtask

    task automatic bounce_inc();
        @(negedge clk);
        btn_inc = 1; repeat (2) @(negedge clk);
        btn_inc = 0; repeat (2) @(negedge clk);
        btn_inc = 1; repeat (2) @(negedge clk);
        btn_inc = 0; repeat (2) @(negedge clk);
        btn_inc = 1; repeat (14) @(negedge clk);
        btn_inc = 0; repeat (16) @(negedge clk);
        model_press(0, 0, 1);
        check_all();
    endtask

    task automatic zero_pulse();
        @(negedge clk);
        zero = 1; repeat (3) @(negedge clk);
        zero = 0; repeat (2) @(negedge clk);
        if (m_st == M_RUN) m_st = M_DONE;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        chk("rst_running", running, 0);
        chk("rst_sel_in", sel_in, 0);
        rst = 1;
        @(negedge clk);
        model_reset();
        check_all();
    endtask

    initial begin
        rst = 0; btn_start = 0; btn_mode = 0; btn_inc = 0; zero = 0;
        model_reset();
        repeat (3) @(negedge clk);
        mon_en = 1;
        check_all();
        rst = 1;
        repeat (2) @(negedge clk);
        check_all();

        // in3 walks 5..9,0..5; then in2 walks 1..5,0,1
        for (int k = 0; k < 10; k++) press(0, 0, 1);
        press(0, 1, 0);
        for (int k = 0; k < 6; k++) press(0, 0, 1);

        // contact bounce before a stable press
        bounce_inc();

        // run from 0015 with pause/resume
        do_reset();
        press(1, 0, 0);
        repeat (35) @(negedge clk);
        press(1, 0, 0);
        repeat (20) @(negedge clk);
        check_all();
        press(1, 0, 0);
        repeat (27) @(negedge clk);
        press(0, 1, 0);
        press(0, 0, 1);
        zero_pulse();
        press(0, 0, 1);
        press(0, 1, 0);

        // all-zero preset cannot start
        for (int k = 0; k < 5; k++) press(0, 0, 1);
        press(0, 1, 0);
        for (int k = 0; k < 5; k++) press(0, 0, 1);
        press(1, 0, 0);
        press(1, 1, 0);

        // simultaneous start + mode: start wins
        press(0, 0, 1);
        press(1, 1, 0);
        press(1, 1, 0);
        press(0, 1, 0);
        press(1, 1, 0);
        zero_pulse();
        press(1, 1, 0);

        // reset mid-run drops edits
        press(0, 0, 1);
        press(1, 0, 0);
        repeat (13) @(negedge clk);
        do_reset();

`ifdef AUTOREPEAT_EN
        drive_btn(0, 0, 1, 70);
        for (int k = 0; k < 4; k++) model_press(0, 0, 1);
        check_all();
`endif

        // randomized walk
        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: press(0, 0, 1);
                4, 5:       press(0, 1, 0);
                6:          press(1, 0, 0);
                7:          press(1, 1, 0);
                8:          zero_pulse();
                default: begin
                    repeat ($urandom_range(5, 30)) @(negedge clk);
                    check_all();
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
